// File: rtl/slice_stim_checker.sv
// slice_stim_checker: drives vectors into the 12-bit inverter/OAI222 slice and checks its C result.
// Define SLICE_CHK_LFSR_EN to use the 24-bit LFSR instead of the index counter as stimulus.
module slice_stim_checker #(
   parameter int NUM_VECTORS   = 4096,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   output logic [11:0] stim_a,
   output logic [11:0] stim_b,
   input  logic [11:0] resp_c,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [15:0] first_err_idx,
   output logic [11:0] first_err_exp
);

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
   localparam logic [3:0]  LAST_CNT = 4'(SETTLE_CYCLES - 1);

   state_t      state_q;
   logic [15:0] idx_q;
   logic [3:0]  cnt_q;
   logic [11:0] stim_a_q;
   logic [11:0] stim_b_q;
   logic        busy_q;
   logic        done_q;
   logic        pass_q;
   logic [15:0] err_q;
   logic [15:0] fidx_q;
   logic [11:0] fexp_q;

   logic [11:0] exp_c;
   logic        mismatch;
   logic [15:0] err_d;
   logic [23:0] stim_d;
   logic        go;

   assign go = (state_q == IDLE) && start && !abort;

   always_comb begin
      exp_c = '0;
      for (int g = 0; g < 3; g++) begin
         exp_c[4*g]   = ~stim_a_q[4*g];
         exp_c[4*g+1] = ~stim_b_q[4*g];
         exp_c[4*g+2] = ~stim_b_q[4*g+1];
         exp_c[4*g+3] = ~((stim_a_q[4*g+1] | stim_a_q[4*g+2]) &
                          (stim_b_q[4*g+1] | stim_b_q[4*g+2]) &
                          (stim_a_q[4*g+3] | stim_b_q[4*g+3]));
      end
   end

   assign mismatch = (resp_c != exp_c);
   assign err_d    = (mismatch && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;

`ifdef SLICE_CHK_LFSR_EN
   logic [23:0] lfsr_q;
   logic [23:0] lfsr_d;

   // Fibonacci taps 24,23,22,17 shifting toward the MSB
   assign lfsr_d = {lfsr_q[22:0],
                    lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]};
   assign stim_d = lfsr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_q <= 24'h000001;
      end else if (go) begin
         lfsr_q <= 24'h000001;
      end else if (state_q == CHECK && !abort) begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   assign stim_d = {~idx_q[11:0], idx_q[11:0]};
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         stim_a_q <= '0;
         stim_b_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= '0;
         fidx_q   <= '0;
         fexp_q   <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (go) begin
                  state_q <= DRIVE;
                  idx_q   <= '0;
                  err_q   <= '0;
                  fidx_q  <= '0;
                  fexp_q  <= '0;
                  busy_q  <= 1'b1;
               end
            end
            DRIVE: begin
               if (abort) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  {stim_b_q, stim_a_q} <= stim_d;
                  cnt_q   <= '0;
                  state_q <= SETTLE;
               end
            end
            SETTLE: begin
               if (abort) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (cnt_q == LAST_CNT) begin
                  state_q <= CHECK;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            CHECK: begin
               if (abort) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  err_q <= err_d;
                  if (mismatch && err_q == 16'd0) begin
                     fidx_q <= idx_q;
                     fexp_q <= exp_c;
                  end
                  if (idx_q == LAST_IDX) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     pass_q  <= (err_d == 16'd0);
                  end else begin
                     idx_q   <= idx_q + 16'd1;
                     state_q <= DRIVE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               pass_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign stim_a        = stim_a_q;
   assign stim_b        = stim_b_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_count     = err_q;
   assign first_err_idx = fidx_q;
   assign first_err_exp = fexp_q;

endmodule

// File: tb/tb_slice_stim_checker.sv
// tb_slice_stim_checker: directed runs with a golden slice model and a run-result scoreboard.
// Build with SLICE_CHK_LFSR_EN defined to exercise the LFSR stimulus source.
module tb_slice_stim_checker;

`ifdef SLICE_CHK_LFSR_EN
   localparam int NV = 3;
`else
   localparam int NV = 16;
`endif
   localparam int SC       = 1;
   localparam int VL       = 2 + SC;
   localparam int TOTAL    = NV * VL;
   localparam int ABORT_AT = (TOTAL > 12) ? 10 : 4;
   localparam int RST_AT   = TOTAL / 2;

   typedef struct packed {
      logic [15:0] err;
      logic        pass;
      logic [15:0] fidx;
      logic [11:0] fexp;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [11:0] stim_a;
   logic [11:0] stim_b;
   logic [11:0] resp_c;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] err_count;
   logic [15:0] first_err_idx;
   logic [11:0] first_err_exp;
   logic        fault;

   int n_pass  = 0;
   int n_total = 0;

   res_t        exp_q[$];
   logic [23:0] stim_q[$];

   always #5 clk = ~clk;

   slice_stim_checker #(
      .NUM_VECTORS  (NV),
      .SETTLE_CYCLES(SC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .stim_a       (stim_a),
      .stim_b       (stim_b),
      .resp_c       (resp_c),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .err_count    (err_count),
      .first_err_idx(first_err_idx),
      .first_err_exp(first_err_exp)
   );

   function automatic logic [11:0] slice(input logic [11:0] a,
                                         input logic [11:0] b);
      logic [11:0] c;
      int o;
      c = '0;
      for (int g = 0; g < 3; g++) begin
         o = 4 * g;
         c[o]   = ~a[o];
         c[o+1] = ~b[o];
         c[o+2] = ~b[o+1];
         c[o+3] = ~((a[o+1] | a[o+2]) & (b[o+1] | b[o+2]) & (a[o+3] | b[o+3]));
      end
      return c;
   endfunction

   // Slice under test, with an optional stuck-at-0 on C[3]
   assign resp_c = fault ? (slice(stim_a, stim_b) & 12'hFF7)
                         : slice(stim_a, stim_b);

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   function automatic void model_run(input bit flt);
      res_t        r;
      logic [23:0] l;
      logic [11:0] a;
      logic [11:0] b;
      logic [11:0] e;
      logic [11:0] c;
      r = '0;
      l = 24'h000001;
      for (int k = 0; k < NV; k++) begin
`ifdef SLICE_CHK_LFSR_EN
         {b, a} = l;
         l = {l[22:0], l[23] ^ l[22] ^ l[21] ^ l[16]};
`else
         a = 12'(k);
         b = ~a;
`endif
         stim_q.push_back({b, a});
         e = slice(a, b);
         c = flt ? (e & 12'hFF7) : e;
         if (c != e) begin
            if (r.err == 16'd0) begin
               r.fidx = 16'(k);
               r.fexp = e;
            end
            r.err = r.err + 16'd1;
         end
      end
      r.pass = (r.err == 16'd0);
      exp_q.push_back(r);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_pass"}, 32'(pass), 32'd0);
      check({tag, "_err"}, 32'(err_count), 32'd0);
      check({tag, "_fidx"}, 32'(first_err_idx), 32'd0);
      check({tag, "_fexp"}, 32'(first_err_exp), 32'd0);
      check({tag, "_stim"}, 32'({stim_b, stim_a}), 32'd0);
   endtask

   task automatic run_full(input string tag, input bit flt, input bit hold);
      res_t        r;
      logic [23:0] s;
      int          early;
      early = 0;
      fault = flt;
      model_run(flt);
      start = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      for (int cyc = 1; cyc <= TOTAL; cyc++) begin
         tick();
         if (cyc % VL == 1 && stim_q.size() > 0) begin
            s = stim_q.pop_front();
            check($sformatf("%s_stim%0d", tag, cyc / VL), 32'({stim_b, stim_a}), 32'(s));
         end
         if (cyc < TOTAL && done) early++;
      end
      check({tag, "_early_done"}, 32'(early), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
      if (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         check({tag, "_err"}, 32'(err_count), 32'(r.err));
         check({tag, "_pass"}, 32'(pass), 32'(r.pass));
         check({tag, "_fidx"}, 32'(first_err_idx), 32'(r.fidx));
         check({tag, "_fexp"}, 32'(first_err_exp), 32'(r.fexp));
      end else begin
         check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      end
      tick();
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      if (hold) begin
         tick();
         check({tag, "_rerun_busy"}, 32'(busy), 32'd1);
         start = 1'b0;
         abort = 1'b1;
         tick();
         abort = 1'b0;
         check({tag, "_rerun_abort"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int dn;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      fault = 1'b0;
      tick();
      tick();
      check_zero("reset");
      rst_n = 1'b1;
      tick();

      run_full("clean", 1'b0, 1'b0);
      check("clean_pass_const", 32'(pass), 32'd0);

      run_full("fault", 1'b1, 1'b0);
`ifndef SLICE_CHK_LFSR_EN
      check("fault_err_const", 32'(err_count), 32'd8);
      check("fault_fexp_const", 32'(first_err_exp), 32'h999);
`endif
      fault = 1'b0;

      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_idle", 32'(busy), 32'd0);
      check("start_abort_hold_err", 32'(err_count), 32'(exp_fault_err()));

      start = 1'b1;
      tick();
      start = 1'b0;
      dn = 0;
      for (int cyc = 1; cyc < ABORT_AT; cyc++) begin
         tick();
         if (done) dn++;
      end
      check("abort_busy_before", 32'(busy), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      for (int cyc = 0; cyc < TOTAL + 4; cyc++) begin
         tick();
         if (done || busy) dn++;
      end
      check("abort_no_done", 32'(dn), 32'd0);

      start = 1'b1;
      tick();
      start = 1'b0;
      for (int cyc = 1; cyc < RST_AT; cyc++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_zero("midreset");
      dn = 0;
      for (int cyc = 0; cyc < TOTAL + 4; cyc++) begin
         tick();
         if (done || busy) dn++;
      end
      check("midreset_no_done", 32'(dn), 32'd0);

      run_full("after_reset", 1'b0, 1'b0);
      run_full("held_start", 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   function automatic int exp_fault_err();
`ifdef SLICE_CHK_LFSR_EN
      logic [23:0] l;
      int          n;
      l = 24'h000001;
      n = 0;
      for (int k = 0; k < NV; k++) begin
         if (slice(l[11:0], l[23:12]) != (slice(l[11:0], l[23:12]) & 12'hFF7))
            n++;
         l = {l[22:0], l[23] ^ l[22] ^ l[21] ^ l[16]};
      end
      return n;
`else
      return 8;
`endif
   endfunction

endmodule
